// File: rtl/rle_encoder_p_if.sv
// rle_encoder_p_if: port-A bundle of the shared dual-port SRAM.
//   master (encoder): drives port_A_clk/addr/we/data_in, samples port_A_data_out.
//   slave  (SRAM)   : the reverse.
// The SRAM is synchronous with one cycle of read latency; addr is a byte
// address, only word-aligned accesses are issued.
`timescale 1ns/1ps
interface rle_encoder_p_if;
  logic        port_A_clk;
  logic [15:0] port_A_addr;
  logic        port_A_we;
  logic [31:0] port_A_data_in;
  logic [31:0] port_A_data_out;

  modport master (
    output port_A_clk, port_A_addr, port_A_we, port_A_data_in,
    input  port_A_data_out
  );

  modport slave (
    input  port_A_clk, port_A_addr, port_A_we, port_A_data_in,
    output port_A_data_out
  );
endinterface

// File: rtl/rle_encoder_p.sv
// rle_encoder_p: parametrised run-length encoder.
// Reads a plaintext frame from SRAM port A, emits (count, symbol) pairs
// (count in the low CNT_W bits, symbol above it), packs PPW pairs per
// 32-bit word from bit 0 upward and writes the words back through port A.
// Runs saturate at 2^CNT_W-1.
//
// Ports:
//   clk, nreset          clock, async active-low reset
//   start                job request, sampled only when idle
//   message_addr/size    plaintext byte address (word aligned) / length in bytes
//   rle_addr             output byte address (word aligned)
//   sram                 port A bundle (rle_encoder_p_if.master)
//   rle_size             compressed length in bytes, valid with done
//   done / busy / err    job complete / job running / bad message_size
//
// Optional feature, macro RLE_STATS_EN: adds max_run (longest run of the
// job) and pair_count (pairs emitted), both valid with done.
`timescale 1ns/1ps
module rle_encoder_p #(
  parameter int SYM_W = 8,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            start,
  input  logic [31:0]     message_addr,
  input  logic [31:0]     message_size,
  input  logic [31:0]     rle_addr,
  rle_encoder_p_if.master sram,
  output logic [31:0]     rle_size,
  output logic            done,
  output logic            busy,
  output logic            err
`ifdef RLE_STATS_EN
  ,
  output logic [CNT_W-1:0] max_run,
  output logic [31:0]      pair_count
`endif
);

  localparam int PAIR_W = SYM_W + CNT_W;
  localparam int PPW    = 32 / PAIR_W;   // pairs per output word
  localparam int SPW    = 32 / SYM_W;    // symbols per input word
  localparam int BPS    = SYM_W / 8;     // bytes per symbol
  localparam int PAIR_B = PAIR_W / 8;    // bytes per pair
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, SCAN, WR, FLUSH, FIN} state_e;

  state_e             state_q, state_d;
  logic [31:0]        rd_ptr_q, rd_ptr_d;
  logic [31:0]        wr_ptr_q, wr_ptr_d;
  logic [31:0]        rem_q, rem_d;        // symbols left in the job
  logic [2:0]         wleft_q, wleft_d;    // symbols left in word_q
  logic [31:0]        word_q, word_d;      // current input word, consumed LSB first
  logic [SYM_W-1:0]   cur_q, cur_d;
  logic [CNT_W-1:0]   run_q, run_d;
  logic               open_q, open_d;      // a run is in progress
  logic               tail_q, tail_d;      // final pair already emitted
  logic [31:0]        buf_q, buf_d;
  logic [1:0]         bcnt_q, bcnt_d;      // pairs held in buf_q
  logic [31:0]        pairs_q, pairs_d;
  logic [31:0]        rle_size_q, rle_size_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic               emit;
  logic [SYM_W-1:0]   sym;
  logic [31:0]        pair_w;
  logic               we_c;
  logic               wr_sel;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rem_q      <= '0;
      wleft_q    <= '0;
      word_q     <= '0;
      cur_q      <= '0;
      run_q      <= '0;
      open_q     <= 1'b0;
      tail_q     <= 1'b0;
      buf_q      <= '0;
      bcnt_q     <= '0;
      pairs_q    <= '0;
      rle_size_q <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rem_q      <= rem_d;
      wleft_q    <= wleft_d;
      word_q     <= word_d;
      cur_q      <= cur_d;
      run_q      <= run_d;
      open_q     <= open_d;
      tail_q     <= tail_d;
      buf_q      <= buf_d;
      bcnt_q     <= bcnt_d;
      pairs_q    <= pairs_d;
      rle_size_q <= rle_size_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    rem_d      = rem_q;
    wleft_d    = wleft_q;
    word_d     = word_q;
    cur_d      = cur_q;
    run_d      = run_q;
    open_d     = open_q;
    tail_d     = tail_q;
    buf_d      = buf_q;
    bcnt_d     = bcnt_q;
    pairs_d    = pairs_q;
    rle_size_d = rle_size_q;
    done_d     = done_q;
    busy_d     = busy_q;
    err_d      = err_q;
    emit       = 1'b0;
    we_c       = 1'b0;
    wr_sel     = 1'b0;
    sym        = word_q[SYM_W-1:0];
    pair_w     = '0;
    pair_w[PAIR_W-1:0] = {cur_q, run_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          rd_ptr_d   = message_addr;
          wr_ptr_d   = rle_addr;
          rem_d      = message_size / 32'(BPS);
          wleft_d    = '0;
          cur_d      = '0;
          run_d      = '0;
          open_d     = 1'b0;
          tail_d     = 1'b0;
          buf_d      = '0;
          bcnt_d     = '0;
          pairs_d    = '0;
          rle_size_d = '0;
          done_d     = 1'b0;
          busy_d     = 1'b1;
          err_d      = (message_size % 32'(BPS)) != 32'd0;
          state_d    = (err_d || message_size == 32'd0) ? FIN : RD_REQ;
        end
      end
      RD_REQ: state_d = RD_WAIT;
      RD_WAIT: begin
        word_d   = sram.port_A_data_out;
        rd_ptr_d = rd_ptr_q + 32'd4;
        // tail word: only the symbols still owed by the frame are consumed
        wleft_d  = (rem_q >= 32'(SPW)) ? 3'(SPW) : rem_q[2:0];
        state_d  = SCAN;
      end
      SCAN: begin
        if (rem_q != 32'd0) begin
          word_d  = word_q >> SYM_W;
          rem_d   = rem_q - 32'd1;
          wleft_d = wleft_q - 3'd1;
          if (!open_q) begin
            cur_d  = sym;
            run_d  = CNT_W'(1);
            open_d = 1'b1;
          end else if (sym == cur_q && run_q != CNT_MAX) begin
            run_d = run_q + CNT_W'(1);
          end else begin
            emit  = 1'b1;
            cur_d = sym;
            run_d = CNT_W'(1);
          end
        end else begin
          // all symbols consumed: this extra pass closes the open run, so a
          // cycle never has to append two pairs
          emit   = 1'b1;
          tail_d = 1'b1;
        end
        if (emit) begin
          buf_d   = buf_q | (pair_w << (32'(bcnt_q) * PAIR_W));
          bcnt_d  = bcnt_q + 2'd1;
          pairs_d = pairs_q + 32'd1;
        end
        if (bcnt_d == 2'(PPW))                   state_d = WR;
        else if (tail_d)                         state_d = FLUSH;
        else if (rem_d != 0 && wleft_d == 3'd0)  state_d = RD_REQ;
        else                                     state_d = SCAN;
      end
      WR: begin
        we_c     = 1'b1;
        wr_sel   = 1'b1;
        wr_ptr_d = wr_ptr_q + 32'd4;
        buf_d    = '0;
        bcnt_d   = '0;
        if (tail_q)                              state_d = FLUSH;
        else if (rem_q != 0 && wleft_q == 3'd0)  state_d = RD_REQ;
        else                                     state_d = SCAN;
      end
      FLUSH: begin
        // partial buffer goes out with zero upper bits; empty buffer skips the write
        wr_sel = 1'b1;
        if (bcnt_q != 2'd0) begin
          we_c     = 1'b1;
          wr_ptr_d = wr_ptr_q + 32'd4;
          buf_d    = '0;
          bcnt_d   = '0;
        end
        state_d = FIN;
      end
      FIN: begin
        done_d     = 1'b1;
        busy_d     = 1'b0;
        rle_size_d = pairs_q * 32'(PAIR_B);
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sram.port_A_clk     = clk;
  assign sram.port_A_we      = we_c;
  assign sram.port_A_addr    = wr_sel ? wr_ptr_q[15:0] : rd_ptr_q[15:0];
  assign sram.port_A_data_in = we_c ? buf_q : 32'd0;

  assign rle_size = rle_size_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign err      = err_q;

`ifdef RLE_STATS_EN
  logic [CNT_W-1:0] max_run_q, max_run_d;

  always_comb begin
    max_run_d = max_run_q;
    if (state_q == IDLE && start)           max_run_d = '0;
    else if (emit && run_q > max_run_q)     max_run_d = run_q;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) max_run_q <= '0;
    else         max_run_q <= max_run_d;
  end

  assign max_run    = max_run_q;
  assign pair_count = pairs_q;
`endif

endmodule

// File: tb/tb_rle_encoder_p.sv
// Bench for rle_encoder_p: two instances (8/8 and 16/16) on a shared
// behavioural SRAM; directed frames plus random frames compared against a
// list-based RLE reference model.
`timescale 1ns/1ps
module tb_rle_encoder_p;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nreset;
  logic        start8, start16;
  logic [31:0] msg_addr, msg_size, out_addr;
  logic [31:0] rsz8, rsz16;
  logic        done8, busy8, err8, done16, busy16, err16;
`ifdef RLE_STATS_EN
  logic [7:0]  mr8;
  logic [15:0] mr16;
  logic [31:0] pc8, pc16;
`endif

  rle_encoder_p_if if8();
  rle_encoder_p_if if16();

  rle_encoder_p #(.SYM_W(8), .CNT_W(8)) u_dut8 (
    .clk(clk), .nreset(nreset), .start(start8), .message_addr(msg_addr),
    .message_size(msg_size), .rle_addr(out_addr), .sram(if8.master),
    .rle_size(rsz8), .done(done8), .busy(busy8), .err(err8)
`ifdef RLE_STATS_EN
    , .max_run(mr8), .pair_count(pc8)
`endif
  );

  rle_encoder_p #(.SYM_W(16), .CNT_W(16)) u_dut16 (
    .clk(clk), .nreset(nreset), .start(start16), .message_addr(msg_addr),
    .message_size(msg_size), .rle_addr(out_addr), .sram(if16.master),
    .rle_size(rsz16), .done(done16), .busy(busy16), .err(err16)
`ifdef RLE_STATS_EN
    , .max_run(mr16), .pair_count(pc16)
`endif
  );

  // shared synchronous SRAM, one-cycle read latency
  logic [31:0] mem [0:16383];
  logic [31:0] rd8, rd16;
  logic        tb_we;
  logic [13:0] tb_wa;
  logic [31:0] tb_wd;
  int          wcnt8 = 0, wcnt16 = 0;

  always @(posedge clk) begin
    rd8  <= mem[if8.port_A_addr[15:2]];
    rd16 <= mem[if16.port_A_addr[15:2]];
    if (if8.port_A_we)  mem[if8.port_A_addr[15:2]]  <= if8.port_A_data_in;
    if (if16.port_A_we) mem[if16.port_A_addr[15:2]] <= if16.port_A_data_in;
    if (tb_we)          mem[tb_wa] <= tb_wd;
  end

  always @(posedge clk) begin
    if (if8.port_A_we)  wcnt8  <= wcnt8 + 1;
    if (if16.port_A_we) wcnt16 <= wcnt16 + 1;
  end

  assign if8.port_A_data_out  = rd8;
  assign if16.port_A_data_out = rd16;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  logic [7:0]  msg[$];
  logic [31:0] exp_w[$];
  int          exp_size, exp_pairs, exp_max;
  bit          exp_err;

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_wa = a[15:2]; tb_wd = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // frame bytes little-endian into words; bytes past the frame are junk
  task automatic load_msg(input logic [31:0] a, input int n);
    logic [31:0] w;
    for (int i = 0; i < (n + 3) / 4; i++) begin
      w = $urandom;
      for (int j = 0; j < 4; j++)
        if (4 * i + j < n) w[8*j +: 8] = msg[4*i + j];
      poke(a + 32'(4 * i), w);
    end
  endtask

  // reference: split into symbols, collapse into saturating runs, pack words
  task automatic build_model(input int symw, input int cntw, input int nbytes);
    int bps, cmax, pw, ppw, idx;
    int syms[$];
    int cnts[$];
    logic [63:0] w;
    bps  = symw / 8;
    cmax = (1 << cntw) - 1;
    exp_w.delete();
    exp_err = (nbytes % bps) != 0;
    if (!exp_err) begin
      for (int i = 0; i < nbytes / bps; i++) begin
        int s;
        s   = (bps == 1) ? int'(msg[i]) : int'({msg[2*i+1], msg[2*i]});
        idx = cnts.size() - 1;
        if (idx >= 0 && syms[idx] == s && cnts[idx] < cmax) cnts[idx]++;
        else begin syms.push_back(s); cnts.push_back(1); end
      end
    end
    pw = symw + cntw; ppw = 32 / pw; w = '0; exp_max = 0;
    for (int k = 0; k < syms.size(); k++) begin
      w |= ((64'(syms[k]) << cntw) | 64'(cnts[k])) << ((k % ppw) * pw);
      if (cnts[k] > exp_max) exp_max = cnts[k];
      if (k % ppw == ppw - 1 || k == syms.size() - 1) begin
        exp_w.push_back(w[31:0]);
        w = '0;
      end
    end
    exp_pairs = syms.size();
    exp_size  = exp_pairs * pw / 8;
  endtask

  task automatic run_job(input string tag, input bit is16, input logic [31:0] ma,
                         input int ms, input logic [31:0] ra, input bit poke_busy);
    int  w0, w1, sw;
    bit  seen;
    sw = is16 ? 16 : 8;
    build_model(sw, sw, ms);
    load_msg(ma, ms);
    for (int k = 0; k <= exp_w.size(); k++) poke(ra + 32'(4 * k), 32'hDEADBEEF);
    w0 = is16 ? wcnt16 : wcnt8;
    @(negedge clk);
    msg_addr = ma; msg_size = 32'(ms); out_addr = ra;
    if (is16) start16 = 1'b1; else start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; start16 = 1'b0;
    chk({tag, ".busy_rise"}, is16 ? busy16 : busy8, 32'd1);
    if (poke_busy) begin
      // a second start mid-job with different inputs must be ignored
      msg_size = 32'd3; out_addr = 32'h0; msg_addr = 32'h40;
      if (is16) start16 = 1'b1; else start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0; start16 = 1'b0;
    end
    seen = 1'b0;
    for (int c = 0; c < 4000 && !seen; c++) begin
      @(negedge clk);
      seen = is16 ? done16 : done8;
    end
    chk({tag, ".done"}, 32'(seen), 32'd1);
    w1 = is16 ? wcnt16 : wcnt8;
    chk({tag, ".busy_fall"}, is16 ? busy16 : busy8, 32'd0);
    chk({tag, ".err"}, is16 ? err16 : err8, 32'(exp_err));
    chk({tag, ".rle_size"}, is16 ? rsz16 : rsz8, 32'(exp_size));
    chk({tag, ".writes"}, 32'(w1 - w0), 32'(exp_w.size()));
    for (int k = 0; k < exp_w.size(); k++)
      chk({tag, ".word"}, mem[(ra >> 2) + 32'(k)], exp_w[k]);
    chk({tag, ".past_end"}, mem[(ra >> 2) + 32'(exp_w.size())], 32'hDEADBEEF);
`ifdef RLE_STATS_EN
    chk({tag, ".max_run"}, is16 ? 32'(mr16) : 32'(mr8), 32'(exp_max));
    chk({tag, ".pair_count"}, is16 ? pc16 : pc8, 32'(exp_pairs));
`endif
  endtask

  task automatic gen_msg(input bit is16, input int nbytes);
    logic [15:0] s;
    msg.delete();
    s = 16'($urandom_range(0, 2)) * 16'h5A3C;
    while (msg.size() < nbytes) begin
      if ($urandom_range(0, 9) < 4) s = 16'($urandom_range(0, 2)) * 16'h5A3C;
      msg.push_back(s[7:0]);
      if (is16) msg.push_back(s[15:8]);
    end
    while (msg.size() > nbytes) void'(msg.pop_back());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int wb, n;
    nreset = 1'b0; start8 = 1'b0; start16 = 1'b0; tb_we = 1'b0;
    tb_wa = '0; tb_wd = '0;
    msg_addr = '0; msg_size = '0; out_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst.we", 32'(if8.port_A_we), 32'd0);
    chk("rst.addr", 32'(if8.port_A_addr), 32'd0);
    chk("rst.data_in", if8.port_A_data_in, 32'd0);
    chk("rst.rle_size", rsz8, 32'd0);
    chk("rst.done", 32'(done8), 32'd0);
    chk("rst.busy", 32'(busy16), 32'd0);
    chk("rst.err", 32'(err16), 32'd0);
    nreset = 1'b1;
    @(negedge clk);

    // three runs across two words, partial tail word flushed
    msg = '{8'hAA, 8'hAA, 8'hAA, 8'hBB, 8'hBB, 8'hCC, 8'hCC, 8'hCC};
    run_job("abc", 1'b0, 32'h1000, 8, 32'h4000, 1'b0);
    chk("abc.w0", mem[32'h4000 >> 2], 32'hBB02AA03);
    chk("abc.w1", mem[(32'h4000 >> 2) + 1], 32'h0000CC03);
    chk("abc.size", rsz8, 32'd6);

    // saturation at 255
    msg.delete();
    for (int i = 0; i < 300; i++) msg.push_back(8'h55);
    run_job("sat", 1'b0, 32'h1100, 300, 32'h4100, 1'b1);
    chk("sat.w0", mem[32'h4100 >> 2], 32'h552D55FF);
    chk("sat.size", rsz8, 32'd4);

    // tail word with three ignored bytes
    msg = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h22};
    run_job("tail", 1'b0, 32'h1200, 5, 32'h4200, 1'b0);
    chk("tail.w0", mem[32'h4200 >> 2], 32'h22011104);

    // 16-bit symbols: odd size is an error, zero size writes nothing
    gen_msg(1'b1, 3);
    run_job("odd16", 1'b1, 32'h1300, 3, 32'h4300, 1'b0);
    chk("odd16.err", 32'(err16), 32'd1);
    chk("odd16.size", rsz16, 32'd0);
    msg.delete();
    run_job("zero16", 1'b1, 32'h1300, 0, 32'h4300, 1'b0);
    chk("zero16.err", 32'(err16), 32'd0);

    // random frames on both widths
    for (int t = 0; t < 24; t++) begin
      bit is16;
      is16 = t[0];
      n = $urandom_range(1, 64);
      if (is16 && $urandom_range(0, 3) != 0) n = n & ~1;
      gen_msg(is16, n);
      run_job(is16 ? "rnd16" : "rnd8", is16, 32'h1000 + 32'(4 * $urandom_range(0, 255)),
              n, 32'h6000 + 32'(4 * $urandom_range(0, 255)),
              (n >= 8) && !(is16 && n[0]));
    end

    // reset after the first write aborts the job
    msg.delete();
    for (int i = 0; i < 64; i++) msg.push_back(i[0] ? 8'h22 : 8'h11);
    load_msg(32'h2000, 64);
    @(negedge clk);
    msg_addr = 32'h2000; msg_size = 32'd64; out_addr = 32'h5000; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      seen = if8.port_A_we;
    end
    chk("abort.first_wr", 32'(seen), 32'd1);
    @(negedge clk);
    nreset = 1'b0;
    #1;
    chk("abort.we", 32'(if8.port_A_we), 32'd0);
    chk("abort.addr", 32'(if8.port_A_addr), 32'd0);
    chk("abort.data_in", if8.port_A_data_in, 32'd0);
    chk("abort.busy", 32'(busy8), 32'd0);
    chk("abort.done", 32'(done8), 32'd0);
    chk("abort.err", 32'(err8), 32'd0);
    chk("abort.rle_size", rsz8, 32'd0);
    wb = wcnt8;
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort.no_writes", 32'(wcnt8 - wb), 32'd0);
    gen_msg(1'b0, 37);
    run_job("after_rst", 1'b0, 32'h2400, 37, 32'h5400, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rle_encoder_p.md
# rle_encoder_p

Parametrised run-length encoder, the next generation of the team's single-width RLE compressor. It reads a plaintext frame from the shared dual-port SRAM through port A and writes (count, symbol) pairs back to the same SRAM. Symbol width and count width are compile-time parameters, and runs saturate at the maximum count. It adds an explicit partial-word flush, tail handling, a busy flag and input error detection.

## Interface
- SYM_W, 8, symbol width in bits; legal values 8 or 16.
- CNT_W, 8, run-count width in bits; legal values 8 or 16. SYM_W+CNT_W must be 16 or 32. PAIR_W = SYM_W+CNT_W; PPW = 32/PAIR_W (pairs per word).
- clk  in  1  clock; port_A_clk is driven from it.
- nreset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- message_addr  in  32  plaintext byte address; 4-byte aligned.
- message_size  in  32  plaintext length in bytes.
- rle_addr  in  32  output byte address; 4-byte aligned.
- port_A_data_out  in  32  SRAM read data.
- port_A_clk  out  1  equal to clk.
- port_A_addr  out  16  byte address, bits [15:0] of the internal read or write pointer.
- port_A_we  out  1  write enable.
- port_A_data_in  out  32  SRAM write data.
- rle_size  out  32  compressed length in bytes.
- done  out  1  job complete; held high until the next accepted start.
- busy  out  1  high from an accepted start until done.
- err  out  1  input error; held high until the next accepted start.

## Operation
- States: IDLE, RD_REQ, RD_WAIT, SCAN, WR, FLUSH, FIN.
- IDLE, start=1: latch all inputs and clear counters, busy, done and err.
  - message_size not a multiple of SYM_W/8 -> err=1, then FIN.
  - message_size=0 -> FIN, rle_size=0, no writes.
  - Otherwise go to RD_REQ.
- RD_REQ: drive the read pointer with we=0, then go to RD_WAIT.
- RD_WAIT: capture port_A_data_out, advance the read pointer by 4, then go to SCAN.
- SCAN: consume one symbol per cycle, least-significant symbol first.
  - A symbol that equals the current symbol while run < 2^CNT_W-1 increments run.
  - Otherwise the current pair is appended to the write buffer, and run restarts at 1 with the new symbol.
  - The first symbol of a job opens a run without emitting a pair.
- Pair layout: count in the low CNT_W bits, symbol in the high SYM_W bits. Pairs fill the 32-bit buffer from bit 0 upward.
- When the buffer holds PPW pairs -> WR: write the buffer at the write pointer, advance the pointer by 4, clear the buffer, and return to SCAN.
- Word exhausted with symbols remaining -> RD_REQ.
- Tail word: only (remaining bytes)/(SYM_W/8) symbols are consumed. Unused bytes are ignored.
- Last symbol consumed:
  - Emit the final pair.
  - If the buffer is full -> WR, then FLUSH.
  - If the buffer is partial -> FLUSH writes it with unused upper bits zero.
  - If the buffer is empty -> FIN with no write.
- rle_size = pairs_emitted*PAIR_W/8.
- FIN: done=1, busy=0, then IDLE.
- start during busy is ignored.
- Pointer arithmetic is 32-bit and wraps modulo 2^32. Only [15:0] reaches the port.

## Timing
- Reset values: port_A_we=0, port_A_addr=0, port_A_data_in=0, rle_size=0, done=0, busy=0, err=0. State is IDLE.
- nreset asserted mid-job aborts immediately. No write occurs after reset assertion.
- The SRAM is synchronous with one-cycle read latency. Data for the address driven in RD_REQ is valid in RD_WAIT.
- Per 32-bit input word: 2 read cycles plus 32/SYM_W SCAN cycles, plus 1 cycle per WR.
- A write is a single cycle with we=1. Address and data are stable throughout that cycle.
- Read and write never occur in the same cycle.
- Latency from start to busy=1 is 1 cycle. done rises 1 cycle after the last write, or after the last SCAN cycle if nothing is written.
- rle_size is valid when done=1 and holds until the next start.

## Configuration
- RLE_STATS_EN defined: adds outputs max_run (CNT_W bits, longest run of the job) and pair_count (32 bits).
  - Both clear on start and are valid with done.
  - Both reset to 0.
- RLE_STATS_EN undefined: neither port nor its logic exists. All other behaviour is identical.

## Test plan
- SYM_W=8, CNT_W=8, frame of 8 bytes AA AA AA BB BB CC CC CC -> words 0xBB02AA03, 0x000000CC03 truncated to 0x0000CC03; rle_size=6; done=1.
- 300 bytes of 0x55 -> pairs (255,55),(45,55) in word 0x552D55FF; rle_size=4 (saturation).
- message_size=5, bytes 11 11 11 11 | 22 xx xx xx -> word 0x22011104; the three tail bytes are ignored.
- SYM_W=16, CNT_W=16, message_size=3 -> err=1, done=1, rle_size=0, no write cycles; message_size=0 -> err=0, rle_size=0, no writes.
- Assert nreset after the first WR -> all outputs return to 0 and no further we pulses occur; a new start then completes normally.
- RLE_STATS_EN defined, 300-byte run -> max_run=255, pair_count=2.
